// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake between a requester and the bit-serial adder sequencer.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    // Sequencer side
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell reused for WIDTH clocks, LSB first.

// Single full-adder cell.
module add_circuit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic z,
    output logic cout
);
    assign z    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_z;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_next;

    // The one shared full-adder cell, fed from the operand LSBs and the carry flop.
    add_circuit u_fa (
        .x    (opa[0]),
        .y    (opb[0]),
        .cin  (carry),
        .z    (fa_z),
        .cout (fa_cout)
    );

    // Partial sum shifts right with the new bit entering at the MSB.
    if (WIDTH == 1) begin : g_acc_w1
        assign acc_next = fa_z;
    end else begin : g_acc_wn
        assign acc_next = {fa_z, acc[WIDTH-1:1]};
    end

    // Sequencer FSM with datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.b;
                        carry  <= bus.cin;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= fa_cout;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    cnt   <= cnt + CW'(1);
                    // Last bit: publish the complete result in one step.
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_q  <= acc_next;
                        cout_q <= fa_cout;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    logic [8:0] prev8;   // expected held {cout,sum} of the 8-bit instance
    logic [1:0] prev1;   // expected held {cout,sum} of the 1-bit instance

    serial_add_ctrl_if #(.WIDTH(8)) if8 ();
    serial_add_ctrl_if #(.WIDTH(1)) if1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One 8-bit operation with full cycle-by-cycle timing and hold checks.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec);
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = c;
        step();                                   // edge k
        if8.start = 1'b0;
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            check("busy8_run", 64'(if8.busy), 64'(1));
            check("done8_run", 64'(if8.done), 64'(0));
            check("hold8_run", 64'({if8.cout, if8.sum}), 64'(prev8));
            if (i < 7) step();
        end
        step();                                   // edge k+8
        check("done8", 64'(if8.done), 64'(1));
        check("busy8_done", 64'(if8.busy), 64'(0));
        check("sum8", 64'(if8.sum), 64'(es));
        check("cout8", 64'(if8.cout), 64'(ec));
        prev8 = {ec, es};
        step();                                   // edge k+9, back to IDLE
        check("done8_after", 64'(if8.done), 64'(0));
        check("busy8_after", 64'(if8.busy), 64'(0));
        check("hold8_after", 64'({if8.cout, if8.sum}), 64'(prev8));
    endtask

    // One 1-bit operation.
    task automatic run1(input logic a, input logic b, input logic c);
        logic [1:0] full;
        full = 2'(a) + 2'(b) + 2'(c);
        if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = c;
        step();
        if1.start = 1'b0; if1.a = ~a; if1.b = ~b; if1.cin = ~c;
        check("busy1_run", 64'(if1.busy), 64'(1));
        check("done1_run", 64'(if1.done), 64'(0));
        check("hold1_run", 64'({if1.cout, if1.sum}), 64'(prev1));
        step();
        check("done1", 64'(if1.done), 64'(1));
        check("res1", 64'({if1.cout, if1.sum}), 64'(full));
        prev1 = full;
        step();
        check("done1_after", 64'(if1.done), 64'(0));
        check("busy1_after", 64'(if1.busy), 64'(0));
    endtask

    initial begin
        int         n_done;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] full;

        n_checks = 0;
        n_err    = 0;
        prev8    = '0;
        prev1    = '0;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        rst = 1'b1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        step();
        step();
        check("rst_busy8", 64'(if8.busy), 64'(0));
        check("rst_done8", 64'(if8.done), 64'(0));
        check("rst_res8", 64'({if8.cout, if8.sum}), 64'(0));
        check("rst_busy1", 64'(if1.busy), 64'(0));
        check("rst_res1", 64'({if1.cout, if1.sum}), 64'(0));
        rst = 1'b0;
        step();

        // Directed vectors
        for (int i = 0; i < 6; i++)
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);

        // start pulses in RUN and in DONE with changed operands are ignored
        if8.start = 1'b1; if8.a = 8'h11; if8.b = 8'h22; if8.cin = 1'b0;
        step();                                   // edge k
        n_done = 0;
        for (int i = 1; i <= 12; i++) begin
            if8.start = (i == 4 || i == 9);
            if8.a = 8'hEE; if8.b = 8'hDD; if8.cin = 1'b1;
            step();                               // edge k+i
            if (if8.done) n_done++;
            if (i == 8) check("ign_sum", 64'({if8.cout, if8.sum}), 64'({1'b0, 8'h33}));
            if (i >= 10) check("ign_idle", 64'(if8.busy), 64'(0));
        end
        if8.start = 1'b0;
        check("ign_done_count", 64'(n_done), 64'(1));
        prev8 = {1'b0, 8'h33};

        // start held high: next accept on edge k+10
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h02; if8.cin = 1'b0;
        step();                                   // edge k
        for (int i = 1; i <= 8; i++) step();      // edge k+8
        check("held_done", 64'(if8.done), 64'(1));
        check("held_sum", 64'({if8.cout, if8.sum}), 64'(9'h003));
        step();                                   // edge k+9
        check("held_idle", 64'(if8.busy), 64'(0));
        step();                                   // edge k+10
        check("held_reaccept", 64'(if8.busy), 64'(1));
        if8.start = 1'b0;
        for (int i = 1; i <= 8; i++) step();      // edge k+18
        check("held_done2", 64'(if8.done), 64'(1));
        check("held_sum2", 64'({if8.cout, if8.sum}), 64'(9'h003));
        step();
        prev8 = 9'h003;

        // Reset in the 4th RUN cycle aborts the operation
        if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'h01; if8.cin = 1'b0;
        step();                                   // edge k, 1st RUN cycle
        if8.start = 1'b0;
        step(); step(); step();                   // 4th RUN cycle
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(if8.busy), 64'(0));
        check("abort_done", 64'(if8.done), 64'(0));
        check("abort_res", 64'({if8.cout, if8.sum}), 64'(0));
        prev8 = '0;
        prev1 = '0;
        step();
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if8.done || if8.busy) n_done++;
        end
        check("abort_quiet", 64'(n_done), 64'(0));
        run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // start coincident with reset is not accepted
        rst = 1'b1; if8.start = 1'b1;
        step();
        if8.start = 1'b0; rst = 1'b0;
        step();
        check("rst_start_busy", 64'(if8.busy), 64'(0));
        prev8 = '0;

        // Randomized against a+b+cin
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            full = 9'(ra) + 9'(rb) + 9'(rc);
            run8(ra, rb, rc, full[7:0], full[8]);
        end

        // WIDTH=1 instance
        run1(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run1(v[2], v[1], v[0]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
